// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST wrapper: FSM states, widths,
// MISR polynomial and the LFSR stepping function.
package c17_bist_pkg;

  localparam int          LFSR_W            = 5;
  localparam int          CUT_OUT_W         = 2;
  localparam logic [15:0] MISR_POLY         = 16'h1021;
  localparam logic [4:0]  LFSR_SEED_DEFAULT = 5'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Maximal-length 5-bit Fibonacci step (period 31, never reaches zero).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register absorbing a 2-bit response per enabled
// cycle; shift-left with polynomial feedback from the MSB.
module bist_misr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       d,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_next;

  always_comb begin
    sig_next = {sig[WIDTH-2:0], 1'b0}
             ^ (sig[WIDTH-1] ? POLY : '0)
             ^ {{(WIDTH-2){1'b0}}, d};
  end

  // clr wins over en so a new run always starts from an empty signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/c17.sv
// ISCAS-85 c17 netlist: six NAND gates, inputs 1,2,3,6,7 and outputs 22,23.
module c17 (
  input  logic [4:0] pat,
  output logic [1:0] resp
);

  logic n1, n2, n3, n6, n7;
  logic n10, n11, n16, n19;

  assign n1  = pat[0];
  assign n2  = pat[1];
  assign n3  = pat[2];
  assign n6  = pat[3];
  assign n7  = pat[4];

  assign n10 = ~(n1 & n3);
  assign n11 = ~(n3 & n6);
  assign n16 = ~(n2 & n11);
  assign n19 = ~(n11 & n7);

  assign resp[0] = ~(n10 & n16);
  assign resp[1] = ~(n16 & n19);

endmodule

// File: rtl/c17_bist_engine.sv
// BIST engine around c17: LFSR pattern source, MISR compactor and a
// three-state run sequencer with golden-signature pass/fail.
module c17_bist_engine
  import c17_bist_pkg::*;
#(
  parameter int               N_PATTERNS = 31,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       seed,
  output logic [4:0]       pat_out,
  input  logic [1:0]       cut_resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      pat_count,
  output logic [1:0]       dbg_state
);

  localparam logic [15:0] N_LAST = 16'(N_PATTERNS);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic              misr_clr, misr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED_DEFAULT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

  // start is a single-cycle request honoured only in IDLE/DONE; abort acts
  // only in RUN and beats a simultaneous start. The aborting cycle's
  // response is still compacted and counted.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 16'd1;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          lfsr_d   = (seed == 5'h00) ? LFSR_SEED_DEFAULT : seed;
          cnt_d    = '0;
          misr_clr = 1'b1;
        end
      end
      RUN: begin
        misr_en = 1'b1;
        lfsr_d  = lfsr_next(lfsr_q);
        cnt_d   = cnt_inc;
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_inc == N_LAST) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  bist_misr #(
    .WIDTH (SIG_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (cut_resp),
    .sig (signature)
  );

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (signature == GOLDEN_SIG);
  assign pat_out   = busy ? lfsr_q : 5'h00;
  assign pat_count = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_c17_bist_engine.sv
// Directed bench for c17_bist_engine: three instances (31-pattern with real
// c17 and fault injection, 6-pattern sequence check, 2-pattern MISR math).
module tb_c17_bist_engine;

  function automatic logic [15:0] ref_sig(input logic [4:0] sd, input int n,
                                          input logic stuck22);
    logic [4:0]  l;
    logic [15:0] m;
    logic g1, g2, g3, g6, g7, n10, n11, n16, n19, y22, y23;
    l = (sd == 5'h00) ? 5'h01 : sd;
    m = 16'h0000;
    for (int i = 0; i < n; i++) begin
      g1  = l[0]; g2 = l[1]; g3 = l[2]; g6 = l[3]; g7 = l[4];
      n10 = ~(g1 & g3);
      n11 = ~(g3 & g6);
      n16 = ~(g2 & n11);
      n19 = ~(n11 & g7);
      y22 = ~(n10 & n16) & ~stuck22;
      y23 = ~(n16 & n19);
      m   = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {14'b0, y23, y22};
      l   = {l[3:0], l[4] ^ l[2]};
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD31 = ref_sig(5'h01, 31, 1'b0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: 31 patterns, real c17, optional stuck-at-0 on output 22
  logic        start_a = 0, abort_a = 0, stuck = 0;
  logic [4:0]  seed_a = 0, pat_a;
  logic [1:0]  cut_a, resp_a, dbg_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] sig_a, cnt_a;

  c17 u_c17_a (.pat(pat_a), .resp(cut_a));
  assign resp_a = {cut_a[1], cut_a[0] & ~stuck};

  c17_bist_engine #(.N_PATTERNS(31), .SIG_W(16), .GOLDEN_SIG(GOLD31)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .seed(seed_a),
    .pat_out(pat_a), .cut_resp(resp_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .pat_count(cnt_a), .dbg_state(dbg_a)
  );

  // Instance B: 6 patterns, real c17
  logic        start_b = 0, abort_b = 0;
  logic [4:0]  seed_b = 0, pat_b;
  logic [1:0]  resp_b, dbg_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_b, cnt_b;

  c17 u_c17_b (.pat(pat_b), .resp(resp_b));

  c17_bist_engine #(.N_PATTERNS(6), .SIG_W(16), .GOLDEN_SIG(16'h0000)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .seed(seed_b),
    .pat_out(pat_b), .cut_resp(resp_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .pat_count(cnt_b), .dbg_state(dbg_b)
  );

  // Instance C: 2 patterns, response forced to 2'b11
  logic        start_c = 0, abort_c = 0;
  logic [4:0]  seed_c = 0, pat_c;
  logic [1:0]  resp_c = 2'b11, dbg_c;
  logic        busy_c, done_c, pass_c;
  logic [15:0] sig_c, cnt_c;

  c17_bist_engine #(.N_PATTERNS(2), .SIG_W(16), .GOLDEN_SIG(16'h0000)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .seed(seed_c),
    .pat_out(pat_c), .cut_resp(resp_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c), .pat_count(cnt_c), .dbg_state(dbg_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [4:0] exp_pat [6];
  int         zeros;

  initial begin
    exp_pat = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};

    // Reset state
    tick(); tick();
    check("rst_pat", 32'(pat_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_pass", 32'(pass_a), 32'h0);
    check("rst_sig", 32'(sig_a), 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    tick();

    // 1: LFSR sequence, 6 patterns
    seed_b = 5'h01; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seq_pat%0d", i), 32'(pat_b), 32'(exp_pat[i]));
      check($sformatf("seq_cnt%0d", i), 32'(cnt_b), 32'(i));
      tick();
    end
    check("seq_done", 32'(done_b), 32'h1);
    check("seq_busy", 32'(busy_b), 32'h0);
    check("seq_pat_idle", 32'(pat_b), 32'h0);
    check("seq_cnt", 32'(cnt_b), 32'd6);
    check("seq_sig", 32'(sig_b), 32'(ref_sig(5'h01, 6, 1'b0)));

    // 2: MISR math with constant response 2'b11
    seed_c = 5'h01; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("misr_clr", 32'(sig_c), 32'h0);
    tick();
    check("misr_c1", 32'(sig_c), 32'h0003);
    check("misr_cnt1", 32'(cnt_c), 32'd1);
    tick();
    check("misr_c2", 32'(sig_c), 32'h0005);
    check("misr_done", 32'(done_c), 32'h1);
    check("misr_cnt2", 32'(cnt_c), 32'd2);
    check("misr_pass", 32'(pass_c), 32'h0);

    // 3: full run with real c17, then with stuck-at-0 on output 22
    seed_a = 5'h01; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (31) tick();
    check("full_done", 32'(done_a), 32'h1);
    check("full_sig", 32'(sig_a), 32'(GOLD31));
    check("full_pass", 32'(pass_a), 32'h1);
    check("full_cnt", 32'(cnt_a), 32'd31);
    stuck = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_done_clr", 32'(done_a), 32'h0);
    check("restart_busy", 32'(busy_a), 32'h1);
    repeat (31) tick();
    check("fault_sig", 32'(sig_a), 32'(ref_sig(5'h01, 31, 1'b1)));
    check("fault_done", 32'(done_a), 32'h1);
    check("fault_pass", 32'(pass_a), 32'h0);
    stuck = 1'b0;

    // 4: zero seed maps to 01 and never emits pattern 0
    seed_a = 5'h00; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("zseed_first", 32'(pat_a), 32'h01);
    zeros = 0;
    repeat (31) begin
      if (pat_a == 5'h00) zeros++;
      tick();
    end
    check("zseed_no_zero", 32'(zeros), 32'h0);
    check("zseed_sig", 32'(sig_a), 32'(GOLD31));
    check("zseed_pass", 32'(pass_a), 32'h1);

    // 5: start while busy ignored; abort+start at RUN cycle 3
    seed_a = 5'h09; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("busy_start_pat", 32'(pat_a), 32'h05);
    check("busy_start_cnt", 32'(cnt_a), 32'd2);
    abort_a = 1'b1; start_a = 1'b1;
    tick();
    abort_a = 1'b0; start_a = 1'b0;
    check("abort_state", 32'(dbg_a), 32'h0);
    check("abort_done", 32'(done_a), 32'h0);
    check("abort_cnt", 32'(cnt_a), 32'd3);
    check("abort_pat", 32'(pat_a), 32'h0);
    check("abort_sig", 32'(sig_a), 32'(ref_sig(5'h09, 3, 1'b0)));
    tick();
    check("abort_stay_idle", 32'(busy_a), 32'h0);
    check("abort_cnt_frozen", 32'(cnt_a), 32'd3);

    // 6: asynchronous reset at RUN cycle 10, then a clean run
    seed_a = 5'h01; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    check("mid_busy", 32'(busy_a), 32'h1);
    check("mid_cnt", 32'(cnt_a), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_pat", 32'(pat_a), 32'h0);
    check("arst_busy", 32'(busy_a), 32'h0);
    check("arst_done", 32'(done_a), 32'h0);
    check("arst_sig", 32'(sig_a), 32'h0);
    check("arst_cnt", 32'(cnt_a), 32'h0);
    check("arst_state", 32'(dbg_a), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    seed_a = 5'h01; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("post_rst_first", 32'(pat_a), 32'h01);
    repeat (31) tick();
    check("post_rst_done", 32'(done_a), 32'h1);
    check("post_rst_sig", 32'(sig_a), 32'(GOLD31));
    check("post_rst_pass", 32'(pass_a), 32'h1);
    check("post_rst_cnt", 32'(cnt_a), 32'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
